// File: rtl/pu_slave_spi_driver_cfg.sv
// SPI slave word engine: configurable mode and bit order, synchronised pin inputs,
// back-to-back words inside one chip-select frame, and mid-word abort detection.
module pu_slave_spi_driver_cfg #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b0,
    parameter bit          MSB_FIRST   = 1'b1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready,
    output logic                  prepare,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  frame_err,
    output logic                  miso,
    input  logic                  mosi,
    input  logic                  sclk,
    input  logic                  cs
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic {
        StIdle,
        StXfer
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   sclk_prev_q;

    logic                  sclk_s;
    logic                  mosi_s;
    logic                  cs_s;
    logic                  lead_edge;
    logic                  trail_edge;
    logic                  sample_edge;
    logic                  shift_edge;

    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d, rx_next;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  miso_q, miso_d;
    logic                  ready_q, ready_d;
    logic                  prep_q, prep_d;
    logic                  dv_q, dv_d;
    logic                  ferr_q, ferr_d;
    logic                  armed_q, armed_d;
    logic                  word_done;

    function automatic logic tx_bit(input logic [DATA_WIDTH-1:0] v);
        return MSB_FIRST ? v[DATA_WIDTH-1] : v[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] tx_shift(input logic [DATA_WIDTH-1:0] v);
        return MSB_FIRST ? {v[DATA_WIDTH-2:0], 1'b0} : {1'b0, v[DATA_WIDTH-1:1]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= {SYNC_STAGES{CPOL}};
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            fill_q      <= '0;
            sclk_prev_q <= CPOL;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign lead_edge   = (sclk_prev_q == CPOL) && (sclk_s != CPOL);
    assign trail_edge  = (sclk_prev_q != CPOL) && (sclk_s == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;

    assign cnt_inc = cnt_q + CNT_W'(1);
    assign rx_next = MSB_FIRST ? {rx_q[DATA_WIDTH-2:0], mosi_s}
                               : {mosi_s, rx_q[DATA_WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        dout_d    = dout_q;
        miso_d    = miso_q;
        ready_d   = ready_q;
        prep_d    = 1'b0;
        dv_d      = 1'b0;
        ferr_d    = 1'b0;
        word_done = 1'b0;
        // A frame may only start once cs has been seen high through a fully refilled
        // synchroniser, so a reset in the middle of a frame cannot resume that frame.
        armed_d   = armed_q | (fill_q[SYNC_STAGES-1] & cs_s);

        unique case (state_q)
            StIdle: begin
                ready_d = 1'b1;
                if (armed_q && !cs_s) begin
                    state_d = StXfer;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                    rx_d    = '0;
                    tx_d    = data_in;
                    if (!CPHA) begin
                        miso_d = tx_bit(data_in);
                        tx_d   = tx_shift(data_in);
                    end
                end
            end
            StXfer: begin
                if (sample_edge) begin
                    rx_d = rx_next;
                    if (cnt_inc == CNT_W'(DATA_WIDTH)) begin
                        word_done = 1'b1;
                        cnt_d     = '0;
                        dout_d    = rx_next;
                        dv_d      = 1'b1;
                        tx_d      = data_in;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_W'(DATA_WIDTH - 1)) begin
                            prep_d = 1'b1;
                        end
                    end
                end else if (shift_edge && !cs_s) begin
                    miso_d = tx_bit(tx_q);
                    tx_d   = tx_shift(tx_q);
                end
                // A sample edge coinciding with cs rising still completes the word.
                if (cs_s) begin
                    state_d = StIdle;
                    ready_d = 1'b1;
                    if (!word_done && (cnt_d != '0)) begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            miso_q  <= 1'b0;
            ready_q <= 1'b1;
            prep_q  <= 1'b0;
            dv_q    <= 1'b0;
            ferr_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            miso_q  <= miso_d;
            ready_q <= ready_d;
            prep_q  <= prep_d;
            dv_q    <= dv_d;
            ferr_q  <= ferr_d;
            armed_q <= armed_d;
        end
    end

    assign ready      = ready_q;
    assign prepare    = prep_q;
    assign data_out   = dout_q;
    assign data_valid = dv_q;
    assign frame_err  = ferr_q;
    assign miso       = miso_q;

endmodule

// File: tb/tb_pu_slave_spi_driver_cfg.sv
// Drives five slave instances (modes 0-3 MSB-first, mode 0 LSB-first) from one
// master waveform and checks received words, read-back data and status pulses.
module tb_pu_slave_spi_driver_cfg;

    localparam int NI = 5;
    localparam int Q  = 4;  // clk cycles per quarter of an sclk period

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic       base;
    logic       mosi;
    logic       mosi_lsb;
    logic       cs;

    logic [NI-1:0] sclk_v, mosi_v, miso_v, ready_v, prep_v, dv_v, ferr_v;
    logic [7:0]    dout_v [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        assign sclk_v[g] = base ^ bit'(g == 2 || g == 3);
        assign mosi_v[g] = (g == 4) ? mosi_lsb : mosi;
        pu_slave_spi_driver_cfg #(
            .DATA_WIDTH (8),
            .CPOL       (bit'(g == 2 || g == 3)),
            .CPHA       (bit'(g == 1 || g == 3)),
            .MSB_FIRST  (bit'(g != 4)),
            .SYNC_STAGES(2)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .data_in   (data_in),
            .ready     (ready_v[g]),
            .prepare   (prep_v[g]),
            .data_out  (dout_v[g]),
            .data_valid(dv_v[g]),
            .frame_err (ferr_v[g]),
            .miso      (miso_v[g]),
            .mosi      (mosi_v[g]),
            .sclk      (sclk_v[g]),
            .cs        (cs)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int dv_cnt   [NI] = '{default: 0};
    int prep_cnt [NI] = '{default: 0};
    int ferr_cnt [NI] = '{default: 0};

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (dv_v[i])   dv_cnt[i]   <= dv_cnt[i] + 1;
            if (prep_v[i]) prep_cnt[i] <= prep_cnt[i] + 1;
            if (ferr_v[i]) ferr_cnt[i] <= ferr_cnt[i] + 1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int unstable = 0;
    int dv0 [NI];
    int prep0 [NI];
    int ferr0 [NI];
    logic [7:0] rd [NI];
    logic       m_at [NI];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic bit is_cpha1(input int i);
        return (i == 1) || (i == 3);
    endfunction

    task automatic snapshot();
        for (int i = 0; i < NI; i++) begin
            dv0[i]   = dv_cnt[i];
            prep0[i] = prep_cnt[i];
            ferr0[i] = ferr_cnt[i];
        end
    endtask

    task automatic sample_grp(input bit cpha1);
        for (int i = 0; i < NI; i++) begin
            if (is_cpha1(i) == cpha1) begin
                m_at[i] = miso_v[i];
                rd[i]   = (i == 4) ? {miso_v[i], rd[i][7:1]} : {rd[i][6:0], miso_v[i]};
            end
        end
    endtask

    task automatic stable_grp(input bit cpha1);
        for (int i = 0; i < NI; i++) begin
            if (is_cpha1(i) == cpha1 && miso_v[i] !== m_at[i]) unstable++;
        end
    endtask

    // One word (or its first nbits) from the master; mosi and data_in change mid-low.
    task automatic xfer_word(input logic [7:0] tx, input logic [7:0] din_next, input int nbits);
        for (int i = 0; i < NI; i++) rd[i] = '0;
        for (int b = 0; b < nbits; b++) begin
            mosi     = tx[7-b];
            mosi_lsb = tx[b];
            if (b == 7) data_in = din_next;
            wait_clk(Q);
            sample_grp(1'b0);
            base = 1'b1;
            wait_clk(Q);
            stable_grp(1'b0);
            wait_clk(Q);
            sample_grp(1'b1);
            base = 1'b0;
            wait_clk(Q);
            stable_grp(1'b1);
        end
    endtask

    task automatic frame(input string nm, input logic [7:0] din_a, input logic [7:0] tx_a,
                         input logic [7:0] din_b, input logic [7:0] tx_b, input int nw);
        snapshot();
        unstable = 0;
        data_in  = din_a;
        cs       = 1'b0;
        wait_clk(2 * Q);
        for (int i = 0; i < NI; i++) check($sformatf("%s.busy%0d", nm, i), 32'(ready_v[i]), 0);
        xfer_word(tx_a, (nw > 1) ? din_b : din_a, 8);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s.rd_a%0d", nm, i), 32'(rd[i]), 32'(din_a));
            check($sformatf("%s.dout_a%0d", nm, i), 32'(dout_v[i]), 32'(tx_a));
        end
        if (nw > 1) begin
            xfer_word(tx_b, din_b, 8);
            for (int i = 0; i < NI; i++) begin
                check($sformatf("%s.rd_b%0d", nm, i), 32'(rd[i]), 32'(din_b));
                check($sformatf("%s.dout_b%0d", nm, i), 32'(dout_v[i]), 32'(tx_b));
            end
        end
        cs = 1'b1;
        wait_clk(2 * Q);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s.ready%0d", nm, i), 32'(ready_v[i]), 1);
            check($sformatf("%s.dv%0d", nm, i), 32'(dv_cnt[i] - dv0[i]), 32'(nw));
            check($sformatf("%s.prep%0d", nm, i), 32'(prep_cnt[i] - prep0[i]), 32'(nw));
            check($sformatf("%s.ferr%0d", nm, i), 32'(ferr_cnt[i] - ferr0[i]), 0);
        end
        check($sformatf("%s.miso_stable", nm), 32'(unstable), 0);
    endtask

    task automatic check_reset_vals(input string nm);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s.ready%0d", nm, i), 32'(ready_v[i]), 1);
            check($sformatf("%s.prep%0d", nm, i), 32'(prep_v[i]), 0);
            check($sformatf("%s.dv%0d", nm, i), 32'(dv_v[i]), 0);
            check($sformatf("%s.ferr%0d", nm, i), 32'(ferr_v[i]), 0);
            check($sformatf("%s.dout%0d", nm, i), 32'(dout_v[i]), 0);
            check($sformatf("%s.miso%0d", nm, i), 32'(miso_v[i]), 0);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        cs       = 1'b1;
        base     = 1'b0;
        mosi     = 1'b0;
        mosi_lsb = 1'b0;
        data_in  = '0;
        wait_clk(5);
        check_reset_vals("rst");
        rst_n = 1'b1;
        wait_clk(8);

        frame("basic", 8'h3C, 8'hA5, 8'h00, 8'h00, 1);
        frame("b2b", 8'h56, 8'h12, 8'h78, 8'h34, 2);
        frame("one", 8'h80, 8'h01, 8'h00, 8'h00, 1);

        // Abort after three bits: error pulse, no data, previous word kept.
        snapshot();
        data_in = 8'h3C;
        cs      = 1'b0;
        wait_clk(2 * Q);
        xfer_word(8'h00, 8'h3C, 3);
        cs = 1'b1;
        wait_clk(2 * Q);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("abort.ferr%0d", i), 32'(ferr_cnt[i] - ferr0[i]), 1);
            check($sformatf("abort.dv%0d", i), 32'(dv_cnt[i] - dv0[i]), 0);
            check($sformatf("abort.dout%0d", i), 32'(dout_v[i]), 32'h01);
            check($sformatf("abort.ready%0d", i), 32'(ready_v[i]), 1);
        end
        frame("ff", 8'hC3, 8'hFF, 8'h00, 8'h00, 1);

        // Reset mid-frame, cs held low across release: must not resume.
        snapshot();
        data_in = 8'h3C;
        cs      = 1'b0;
        wait_clk(2 * Q);
        xfer_word(8'hF0, 8'h3C, 4);
        rst_n = 1'b0;
        wait_clk(2);
        check_reset_vals("midrst");
        rst_n = 1'b1;
        wait_clk(12);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rearm.ready%0d", i), 32'(ready_v[i]), 1);
            check($sformatf("rearm.ferr%0d", i), 32'(ferr_cnt[i] - ferr0[i]), 0);
        end
        cs = 1'b1;
        wait_clk(2 * Q);
        frame("post", 8'h5A, 8'h81, 8'h00, 8'h00, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
